stall_control_multi: RTL and testbench

Parametrised pipeline stall controller for the issue stage. It merges a programmable-length branch shadow, N generic stall request lines and a halt/resume state machine into one StallEn. It also reports the highest-priority stall cause and keeps a saturating count of stalled cycles for performance monitoring. It sits between the hazard/issue logic and the fetch/decode stall inputs.

---
 rtl/stall_control_multi_if.sv | 32 +++
 rtl/stall_control_multi.sv | 130 +++++++++++++
 tb/tb_stall_control_multi.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/stall_control_multi_if.sv
// rtl/stall_control_multi_if.sv - issue-stage to stall-controller signal bundle
interface stall_control_multi_if #(
   parameter int NUM_STALL_SRC = 4,
   parameter int CNT_WIDTH     = 16,
   parameter int CAUSE_W       = $clog2(NUM_STALL_SRC + 3)
);
   // Requests from hazard/issue logic
   logic                     InstructionValid;
   logic                     BranchStallIn;
   logic [NUM_STALL_SRC-1:0] StallSrcIn;
   logic                     HaltStallIn;
   logic                     ResumeIn;
   logic                     CounterClear;

   // Status back to the pipeline and performance monitor
   logic                     Halted;
   logic                     StallEn;
   logic [CAUSE_W-1:0]       StallCause;
   logic [CNT_WIDTH-1:0]     StallCycles;

   // Issue/hazard side: raises requests, observes the stall decision
   modport master (
      output InstructionValid, BranchStallIn, StallSrcIn, HaltStallIn, ResumeIn, CounterClear,
      input  Halted, StallEn, StallCause, StallCycles
   );

   // Stall controller side
   modport slave (
      input  InstructionValid, BranchStallIn, StallSrcIn, HaltStallIn, ResumeIn, CounterClear,
      output Halted, StallEn, StallCause, StallCycles
   );
endinterface

// File: rtl/stall_control_multi.sv
// rtl/stall_control_multi.sv - merges branch shadow, generic stalls and halt FSM into one stall
module stall_control_multi #(
   parameter int NUM_STALL_SRC = 4,
   parameter int BRANCH_DELAY  = 1,
   parameter int CNT_WIDTH     = 16,
   localparam int CAUSE_W      = $clog2(NUM_STALL_SRC + 3)
) (
   input logic clk,
   input logic async_rst,
   input logic clk_en,
   stall_control_multi_if.slave bus
);

   localparam int BCW = $clog2(BRANCH_DELAY + 1);

   // Cause codes; generic sources occupy CAUSE_SRC0 + index
   localparam logic [CAUSE_W-1:0] CAUSE_NONE   = CAUSE_W'(0);
   localparam logic [CAUSE_W-1:0] CAUSE_HALT   = CAUSE_W'(1);
   localparam logic [CAUSE_W-1:0] CAUSE_BRANCH = CAUSE_W'(2);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      RESUME = 2'd2
   } haltState_t;

   haltState_t           haltState;
   logic                 haltedReg;
   logic [BCW-1:0]       branchCnt;
   logic [CNT_WIDTH-1:0] stallCycles;

   logic                 branchStall;
   logic                 fsmStall;
   logic                 srcStall;
   logic                 stallEn;
   logic [CAUSE_W-1:0]   stallCause;

   // Branch shadow: a new branch always reloads, otherwise count down to idle
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         branchCnt <= '0;
      end else if (clk_en) begin
         if (bus.InstructionValid && bus.BranchStallIn) begin
            branchCnt <= BCW'(BRANCH_DELAY);
         end else if (branchCnt != '0) begin
            branchCnt <= branchCnt - BCW'(1);
         end
      end
   end

   // Halt FSM; Halted is registered alongside the state so it never glitches
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         haltState <= RUN;
         haltedReg <= 1'b0;
      end else if (clk_en) begin
         case (haltState)
            RUN: begin
               if (bus.HaltStallIn) begin
                  haltState <= HALTED;
                  haltedReg <= 1'b1;
               end
            end
            HALTED: begin
               // A resume racing a fresh halt request loses; the halt wins
               if (bus.ResumeIn && !bus.HaltStallIn) begin
                  haltState <= RESUME;
                  haltedReg <= 1'b0;
               end
            end
            RESUME: begin
               // Single drain cycle before running again
               if (bus.HaltStallIn) begin
                  haltState <= HALTED;
                  haltedReg <= 1'b1;
               end else begin
                  haltState <= RUN;
                  haltedReg <= 1'b0;
               end
            end
            default: begin
               haltState <= RUN;
               haltedReg <= 1'b0;
            end
         endcase
      end
   end

   // Stall decision and highest-priority cause, same cycle as the requests
   always_comb begin
      branchStall = (branchCnt != '0);
      fsmStall    = bus.HaltStallIn || (haltState != RUN);
      srcStall    = |bus.StallSrcIn;
      stallEn     = branchStall || srcStall || fsmStall;

      // Walk from the lowest-priority source upwards so the lowest index wins
      stallCause = CAUSE_NONE;
      for (int i = NUM_STALL_SRC - 1; i >= 0; i--) begin
         if (bus.StallSrcIn[i]) begin
            stallCause = CAUSE_W'(i + 3);
         end
      end
      if (branchStall) begin
         stallCause = CAUSE_BRANCH;
      end
      if (fsmStall) begin
         stallCause = CAUSE_HALT;
      end
   end

   // Saturating stalled-cycle counter; clear is honoured even with clk_en low
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         stallCycles <= '0;
      end else if (bus.CounterClear) begin
         stallCycles <= '0;
      end else if (clk_en && stallEn && (stallCycles != {CNT_WIDTH{1'b1}})) begin
         stallCycles <= stallCycles + CNT_WIDTH'(1);
      end
   end

   // Drive the status half of the bundle
   always_comb begin
      bus.Halted      = haltedReg;
      bus.StallEn     = stallEn;
      bus.StallCause  = stallCause;
      bus.StallCycles = stallCycles;
   end

endmodule

// File: tb/tb_stall_control_multi.sv
// tb/tb_stall_control_multi.sv - scoreboard bench for stall_control_multi
module tb_stall_control_multi;

   logic clk       = 1'b1;
   logic async_rst = 1'b1;
   logic clk_en    = 1'b1;

   stall_control_multi_if #(.NUM_STALL_SRC(4), .CNT_WIDTH(4)) bus ();

   stall_control_multi #(
      .NUM_STALL_SRC(4),
      .BRANCH_DELAY (3),
      .CNT_WIDTH    (4)
   ) dut (
      .clk      (clk),
      .async_rst(async_rst),
      .clk_en   (clk_en),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       en;
      logic [2:0] cause;
      logic       halted;
      logic [3:0] cyc;
   } exp_t;

   exp_t  expQ[$];
   string nameQ[$];
   exp_t  mExp;
   string mName;
   int    checks = 0;
   int    errors = 0;

   task automatic check1(input string nm, input string field, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s %s got %0d expected %0d", nm, field, got, exp);
      end
   endtask

   // Monitor: outputs are sampled mid-cycle and matched against the scoreboard
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         mExp  = expQ.pop_front();
         mName = nameQ.pop_front();
         check1(mName, "StallEn",     int'(bus.StallEn),     int'(mExp.en));
         check1(mName, "StallCause",  int'(bus.StallCause),  int'(mExp.cause));
         check1(mName, "Halted",      int'(bus.Halted),      int'(mExp.halted));
         check1(mName, "StallCycles", int'(bus.StallCycles), int'(mExp.cyc));
      end
   end

   // Apply one cycle of inputs and queue the outputs expected during that cycle
   task automatic step(input logic r, input logic ce, input logic iv, input logic br,
                       input logic [3:0] src, input logic halt, input logic res, input logic clr,
                       input logic eEn, input logic [2:0] eCause, input logic eH,
                       input logic [3:0] eCyc, input string nm);
      async_rst            = r;
      clk_en               = ce;
      bus.InstructionValid = iv;
      bus.BranchStallIn    = br;
      bus.StallSrcIn       = src;
      bus.HaltStallIn      = halt;
      bus.ResumeIn         = res;
      bus.CounterClear     = clr;
      expQ.push_back({eEn, eCause, eH, eCyc});
      nameQ.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      //   r ce iv br src     hl rs cl  en cs h cyc
      step(1, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0,  "in_reset");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0,  "idle");
      step(0, 1, 0, 0, 4'b0110, 0, 0, 0, 1, 4, 0, 0,  "src_0110");
      step(0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 3, 0, 1,  "src_0001");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 2,  "src_off");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 2,  "clear_a");
      // branch shadow, BRANCH_DELAY=3
      step(0, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0,  "br_issue");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 0,  "br_sh1");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 1,  "br_sh2");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 2,  "br_sh3");
      step(0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 3,  "br_novalid");
      step(0, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 3,  "valid_nobr");
      step(0, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 3,  "rl_issue");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 3,  "rl_sh1");
      step(0, 1, 1, 1, 4'b0000, 0, 0, 0, 1, 2, 0, 4,  "rl_reload");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 5,  "rl_sh1b");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 6,  "rl_sh2b");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 7,  "rl_sh3b");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 8,  "rl_done");
      step(0, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 8,  "fz_issue");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 8,  "fz_sh1");
      step(0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 9,  "fz_hold1");
      step(0, 0, 1, 1, 4'b0000, 0, 0, 0, 1, 2, 0, 9,  "fz_hold2");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 9,  "fz_sh2");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 10, "fz_sh3");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 11, "fz_done");
      step(0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 11, "clear_noen");
      // halt / resume
      step(0, 1, 0, 0, 4'b0000, 1, 0, 0, 1, 1, 0, 0,  "halt_req");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 1, 1, 1,  "halted");
      step(0, 1, 0, 0, 4'b0000, 1, 1, 0, 1, 1, 1, 2,  "res_and_halt");
      step(0, 0, 0, 0, 4'b0000, 0, 1, 0, 1, 1, 1, 3,  "res_noen");
      step(0, 1, 0, 0, 4'b0000, 0, 1, 0, 1, 1, 1, 3,  "resume");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 1, 0, 4,  "resume_st");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 5,  "run_again");
      step(0, 1, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 5,  "res_in_run");
      step(0, 1, 0, 0, 4'b0000, 1, 0, 0, 1, 1, 0, 5,  "halt2_req");
      step(0, 1, 0, 0, 4'b0000, 0, 1, 0, 1, 1, 1, 6,  "halt2_res");
      step(0, 1, 0, 0, 4'b0000, 1, 0, 0, 1, 1, 0, 7,  "resume_rehalt");
      step(0, 1, 0, 0, 4'b0000, 0, 1, 0, 1, 1, 1, 8,  "rehalted_res");
      step(0, 1, 0, 0, 4'b0000, 0, 1, 0, 1, 1, 0, 9,  "res_in_resume");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 10, "run_third");
      // priority
      step(0, 1, 1, 1, 4'b0001, 1, 0, 0, 1, 1, 0, 10, "pri_all");
      step(0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 1, 1, 11, "pri_halted");
      step(0, 1, 1, 1, 4'b0001, 0, 1, 0, 1, 1, 1, 12, "pri_res_br");
      step(0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 1, 0, 13, "pri_resume");
      step(0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 2, 0, 14, "pri_branch1");
      step(0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 2, 0, 15, "pri_branch2");
      step(0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 3, 0, 15, "pri_src0");
      step(0, 1, 0, 0, 4'b1000, 0, 0, 0, 1, 6, 0, 15, "pri_src3");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 15, "pri_none");
      // saturation
      step(0, 1, 0, 0, 4'b0001, 0, 0, 1, 1, 3, 0, 15, "sat_clr");
      for (int k = 1; k <= 20; k++) begin
         step(0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 3, 0, (k > 16) ? 4'd15 : 4'(k - 1), "sat_cnt");
      end
      step(0, 1, 0, 0, 4'b0001, 0, 0, 1, 1, 3, 0, 15, "clr_stall");
      step(0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 3, 0, 0,  "after_clr");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1,  "count_one");
      // asynchronous reset mid-halt and mid-shadow
      step(0, 1, 1, 1, 4'b0000, 1, 0, 0, 1, 1, 0, 1,  "pre_rst");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 1, 1, 2,  "pre_rst_halt");
      step(1, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0,  "async_rst");
      step(1, 1, 0, 0, 4'b0010, 0, 0, 0, 1, 4, 0, 0,  "rst_comb");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0,  "rst_release");
      step(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0,  "rst_idle");

      @(negedge clk);
      #1;
      check1("drain", "pending", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
